// File: rtl/eth_rx_pkg.sv
// Shared types for the Ethernet receiver port arbiter.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } arb_state_t;

  typedef logic [7:0] byte_t;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/eth_rx_port_arb_rr_pick.sv
// Round-robin winner selection: searches req starting one past last_winner.
module rr_pick #(
  parameter  int unsigned NUM_PORTS = 4,
  localparam int unsigned AW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [AW-1:0]        last_winner,
  output logic [AW-1:0]        winner,
  output logic                 any
);

  // Offset 1 is checked first, so last_winner itself ranks lowest.
  always_comb begin
    logic [AW-1:0] idx;
    winner = last_winner;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = AW'((32'(last_winner) + i) % NUM_PORTS);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_rx_port_arb.sv
// Shares one Ethernet byte-stream receiver among NUM_PORTS ingress ports.
// Optional frame watchdog enabled by defining ETH_RX_ARB_WATCHDOG_EN.
module eth_rx_port_arb
  import eth_rx_pkg::*;
#(
  parameter  int unsigned NUM_PORTS      = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 2048,
  localparam int unsigned AW             = $clog2(NUM_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [NUM_PORTS-1:0][7:0] port_data,
  output logic [NUM_PORTS-1:0]      gnt,
  output logic                      rx_start,
  output byte_t                     rx_data,
  input  logic                      rx_ready,
  output logic                      rx_flush,
  output logic [AW-1:0]             active_port,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      timeout_err
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
    $error("eth_rx_port_arb: NUM_PORTS must be 2..16");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("eth_rx_port_arb: TIMEOUT_CYCLES must be 1..65536");
  end

  arb_state_t           state_q, state_d;
  logic [AW-1:0]        active_q, active_d;
  logic [AW-1:0]        last_q, last_d;
  logic [NUM_PORTS-1:0] gnt_d;
  logic                 rx_start_d, busy_d, frame_done_d;
  logic [AW-1:0]        pick_winner;
  logic                 pick_any;

`ifdef ETH_RX_ARB_WATCHDOG_EN
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rx_flush_d, timeout_err_d;
`endif

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
    .req         (req),
    .last_winner (last_q),
    .winner      (pick_winner),
    .any         (pick_any)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    last_d       = last_q;
    rx_start_d   = 1'b0;
    frame_done_d = 1'b0;
`ifdef ETH_RX_ARB_WATCHDOG_EN
    cnt_d         = cnt_q;
    rx_flush_d    = 1'b0;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rx_ready && pick_any) begin
          active_d   = pick_winner;
          rx_start_d = 1'b1;
          state_d    = START;
`ifdef ETH_RX_ARB_WATCHDOG_EN
          cnt_d = '0;
`endif
        end
      end
      START: state_d = STREAM;
      STREAM: begin
        if (rx_ready) begin
          state_d      = IDLE;
          last_d       = active_q;
          frame_done_d = 1'b1;
        end
`ifdef ETH_RX_ARB_WATCHDOG_EN
        else if (cnt_q >= CNT_LIMIT) begin
          state_d       = FLUSH;
          rx_flush_d    = 1'b1;
          timeout_err_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
`ifdef ETH_RX_ARB_WATCHDOG_EN
      FLUSH: begin
        state_d = IDLE;
        last_d  = active_q;
      end
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    gnt_d  = (state_d == START || state_d == STREAM) ? (NUM_PORTS'(1) << active_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      active_q    <= '0;
      last_q      <= AW'(NUM_PORTS - 1);
      gnt         <= '0;
      rx_start    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      last_q      <= last_d;
      gnt         <= gnt_d;
      rx_start    <= rx_start_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
    end
  end

`ifdef ETH_RX_ARB_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rx_flush    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rx_flush    <= rx_flush_d;
      timeout_err <= timeout_err_d;
    end
  end
`else
  assign rx_flush    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign active_port = active_q;
  // Byte mux is selected purely by registered state; port_data is a data path.
  assign rx_data = (state_q == STREAM) ? port_data[active_q] : 8'h00;

endmodule

// File: tb/tb_eth_rx_port_arb.sv
// Randomized self-checking bench for eth_rx_port_arb against a frame-level model.
module tb_eth_rx_port_arb;
  import eth_rx_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned TO = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N-1:0][7:0]   port_data;
  logic [N-1:0]        gnt;
  logic                rx_start;
  byte_t               rx_data;
  logic                rx_ready;
  logic                rx_flush;
  logic [AW-1:0]       active_port;
  logic                busy;
  logic                frame_done;
  logic                timeout_err;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   last_winner;
  logic exp_fd;

  always #5 clk = ~clk;

  eth_rx_port_arb #(.NUM_PORTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .port_data   (port_data),
    .gnt         (gnt),
    .rx_start    (rx_start),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_flush    (rx_flush),
    .active_port (active_port),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance one cycle, apply inputs, then let combinational outputs settle.
  task automatic cyc(input logic [N-1:0] r, input logic rdy);
    @(posedge clk);
    #1;
    req      = r;
    rx_ready = rdy;
    for (int i = 0; i < N; i++) port_data[i] = 8'($urandom);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] m);
    for (int i = 1; i <= N; i++) begin
      int p;
      p = (last_winner + i) % N;
      if (m[p]) return p;
    end
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_start"}, 32'(rx_start), 0);
    check({tag, "_data"}, 32'(rx_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(frame_done), 32'(exp_fd));
    check({tag, "_flush"}, 32'(rx_flush), 0);
    exp_fd = 1'b0;
  endtask

  // One arbitration + frame of nbytes; the last byte cycle raises rx_ready.
  task automatic run_frame(input logic [N-1:0] m, input int nbytes, output logic [N-1:0] g);
    int w;
    cyc(m, 1'b1);
    check_idle("arb");
    w = pick(m);
    cyc(N'($urandom), 1'($urandom));
    g = gnt;
    check("start_pulse", 32'(rx_start), 1);
    check("start_gnt", 32'(gnt), 32'(1) << w);
    check("start_port", 32'(active_port), 32'(w));
    check("start_data", 32'(rx_data), 0);
    check("start_busy", 32'(busy), 1);
    for (int b = 0; b < nbytes; b++) begin
      cyc(N'($urandom), (b == nbytes - 1));
      check("strm_data", 32'(rx_data), 32'(port_data[w]));
      check("strm_gnt", 32'(gnt), 32'(1) << w);
      check("strm_start", 32'(rx_start), 0);
    end
    last_winner = w;
    exp_fd      = 1'b1;
  endtask

  initial begin
    logic [N-1:0] g;
    int           w;
    rst = 1'b1; req = '0; rx_ready = 1'b0; port_data = '0;
    last_winner = N - 1;
    exp_fd      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_port", 32'(active_port), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_to", 32'(timeout_err), 0);
    rst = 1'b0;

    // Single request on port 2, then an idle cycle showing frame_done.
    run_frame(4'b0100, 5, g);
    check("single_gnt", 32'(g), 32'h4);
    cyc('0, 1'b1);
    check_idle("single_done");
    cyc('0, 1'b1);
    check_idle("single_quiet");

    // rx_ready low in IDLE blocks arbitration.
    cyc(4'b0010, 1'b0);
    check_idle("notready");
    cyc('0, 1'b1);
    check_idle("notready_hold");

    // Fairness: all ports requesting, back-to-back frames.
    for (int k = 0; k < 8; k++) begin
      run_frame(4'b1111, 1 + (k % 3), g);
      check("fair_order", 32'(g), 32'(1) << ((k + 3) % 4));
    end

    // Early drop after 3 bytes; next port is arbitrated right away.
    run_frame(4'b0011, 3, g);
    run_frame(4'b0011, 2, g);
    cyc('0, 1'b1);
    check_idle("drop_done");

    // Randomized frames with random gaps.
    for (int k = 0; k < 40; k++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      run_frame(m, $urandom_range(1, 8), g);
      for (int j = 0; j < $urandom_range(0, 2); j++) begin
        cyc('0, 1'($urandom));
        check_idle("gap");
      end
    end

    // Watchdog behaviour (or indefinite hold without it).
    cyc(4'b1000, 1'b1);
    check_idle("wd_arb");
    w = pick(4'b1000);
    cyc('0, 1'b0);
    check("wd_start", 32'(rx_start), 1);
`ifdef ETH_RX_ARB_WATCHDOG_EN
    for (int k = 1; k <= TO; k++) begin
      cyc('0, 1'b0);
      check("wd_hold_gnt", 32'(gnt), 32'(1) << w);
      check("wd_hold_flush", 32'(rx_flush), 0);
    end
    cyc('0, 1'b0);
    check("wd_flush", 32'(rx_flush), 1);
    check("wd_err", 32'(timeout_err), 1);
    check("wd_gnt", 32'(gnt), 0);
    check("wd_nodone", 32'(frame_done), 0);
    check("wd_data", 32'(rx_data), 0);
    last_winner = w;
    cyc('0, 1'b1);
    check_idle("wd_after");
    check("wd_err_clr", 32'(timeout_err), 0);
`else
    for (int k = 0; k < 40; k++) begin
      cyc('0, 1'b0);
      check("nowd_gnt", 32'(gnt), 32'(1) << w);
      check("nowd_flush", 32'(rx_flush), 0);
      check("nowd_err", 32'(timeout_err), 0);
    end
    cyc('0, 1'b1);
    check("nowd_end_gnt", 32'(gnt), 32'(1) << w);
    last_winner = w;
    exp_fd      = 1'b1;
    cyc('0, 1'b1);
    check_idle("nowd_after");
`endif

    // Mid-frame reset, then priority restarts at port 0.
    cyc(4'b0110, 1'b1);
    check_idle("mr_arb");
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    check("mr_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1; req = 4'b1001; rx_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; req = '0; rx_ready = 1'b1;
    #1;
    exp_fd = 1'b0;
    check_idle("mr_rst");
    check("mr_port", 32'(active_port), 0);
    check("mr_err", 32'(timeout_err), 0);
    last_winner = N - 1;
    run_frame(4'b1001, 2, g);
    check("mr_first", 32'(g), 32'h1);
    run_frame(4'b1001, 2, g);
    check("mr_second", 32'(g), 32'h8);
    cyc('0, 1'b1);
    check_idle("mr_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_port_arb.md
# eth_rx_port_arb

Round-robin arbiter and sequencer that shares one Ethernet byte-stream receiver among `NUM_PORTS` ingress ports. It sits between the ingress port buffers and the receiver. It grants one port at a time, issues the receiver's `start` pulse, muxes the granted port's bytes onto the receiver's `data` input, and releases the grant when the receiver returns to idle. An optional watchdog flushes frames that never terminate.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of ingress ports, legal range 2..16.
- `TIMEOUT_CYCLES`, 2048: STREAM-state cycle limit; used only with the watchdog.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_PORTS  per-port "frame pending", level-sensitive.
- `port_data`  in  NUM_PORTS x 8  per-port byte stream.
- `gnt`  out  NUM_PORTS  one-hot grant; all zero when no port is granted.
- `rx_start`  out  1  one-cycle start pulse to the receiver.
- `rx_data`  out  8  byte to the receiver.
- `rx_ready`  in  1  receiver idle indication.
- `rx_flush`  out  1  one-cycle receiver flush; the top level ORs it into the receiver's reset.
- `active_port`  out  $clog2(NUM_PORTS)  index of the granted port; holds its last value when idle.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when a granted frame completes normally.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, START, STREAM, FLUSH.
- IDLE:
  - If `rx_ready && |req`, pick a winner round-robin, starting the search at `last_winner+1` mod NUM_PORTS.
  - Register the winner into `active_port` and move to START.
  - Otherwise stay in IDLE.
- START:
  - Assert `gnt[active_port]` and `rx_start=1` for exactly one cycle.
  - Ignore `rx_ready` in this state; the receiver is still idle during it.
  - Go to STREAM.
- STREAM:
  - `gnt[active_port]=1` and `rx_data=port_data[active_port]`.
  - The granted port drives a new byte every cycle, starting the cycle after START.
  - When `rx_ready==1`: move to IDLE, pulse `frame_done` in the first IDLE cycle, and set `last_winner=active_port`.
  - This one rule covers both normal completion and an early receiver drop, such as a destination-MAC mismatch.
- FLUSH (watchdog only):
  - `rx_flush=1` and `timeout_err=1` for one cycle; `gnt` is zero.
  - Set `last_winner=active_port`, then go to IDLE.
  - `frame_done` is not pulsed.
- `rx_data` is 8'h00 in every state except STREAM.
- Ports treat the falling edge of `gnt` as an abort and discard the rest of the frame.
- `req` changes on the granted port during START or STREAM are ignored; the grant is never revoked early.
- A port whose `req` is still high after its frame is re-eligible immediately, but ranks lowest in the next arbitration.
- After reset `last_winner=NUM_PORTS-1`, so port 0 has highest priority.

## Timing
- Reset values: state IDLE, `gnt=0`, `rx_start=0`, `rx_data=0`, `rx_flush=0`, `active_port=0`, `busy=0`, `frame_done=0`, `timeout_err=0`.
- Reset asserted mid-frame returns to IDLE on the next edge; `frame_done` is not pulsed.
- All outputs are registered or decoded from registered state only; there is no combinational path from `req` or `rx_ready` to any output.
- Latency: `req` high in IDLE cycle T gives `rx_start` and `gnt` in T+1, and the first byte is sampled in T+2.
- `rx_ready` high in STREAM cycle E makes `gnt` low in E+1; the earliest next `rx_start` is E+2.
- Watchdog STREAM counter: 16-bit, cleared on entry to START, saturating. When it reaches `TIMEOUT_CYCLES-1` in STREAM with `rx_ready==0`, the next state is FLUSH.
- If `rx_ready` rises in the same cycle the counter reaches its limit, normal completion wins.

## Configuration
- `ETH_RX_ARB_WATCHDOG_EN` defined: the STREAM counter and the FLUSH state exist, and `TIMEOUT_CYCLES` is active.
- `ETH_RX_ARB_WATCHDOG_EN` undefined: no counter and no FLUSH state. `rx_flush` and `timeout_err` are tied to 0, and STREAM exits only on `rx_ready`.

## Structure
- Shared package `eth_rx_pkg`: the `arb_state_t` enum (IDLE, START, STREAM, FLUSH) and the byte typedef `byte_t`.
- One sub-module, `rr_pick`: combinational round-robin winner selection from `req` and `last_winner`.
  - Outputs: `winner` index and `any` flag.
  - Lives in its own file.
- The FSM, datapath mux and watchdog stay in the top module.

## Test plan
- Single request: `req=4'b0100` with `rx_ready` high. Expect `rx_start` and `gnt=4'b0100` one cycle later and `active_port=2`. Port 2's bytes appear on `rx_data`. When the receiver raises `rx_ready`, expect `gnt=0` next cycle and `frame_done` pulsed once.
- Fairness: `req=4'b1111` held for 8 frames. Grant order must be 0,1,2,3,0,1,2,3, with no port granted twice in a row.
- Early drop: the receiver rejects the destination MAC after 3 bytes. `rx_ready` goes high in STREAM, expect `gnt` to fall next cycle and `frame_done=1`. Arbitration of the next port starts one cycle later.
- Watchdog: with `TIMEOUT_CYCLES=16` and `rx_ready` held 0 after start, expect `rx_flush` and `timeout_err` on the 17th cycle after `rx_start` and no `frame_done`. Repeat with the macro undefined: the grant must hold indefinitely.
- Mid-frame reset: assert `rst` during STREAM. Next cycle all outputs are at reset values; after release, `req=4'b1001` grants port 0 first.
